mem_port_arbiter: RTL and testbench

Shares the single synchronous memory port between the femto RISC-V core and a secondary bus master (debug/DMA loader). The core has no stall input, so it always has absolute priority and its requests pass straight through. Secondary requests are buffered in a small FIFO and issued only in cycles where the core is not accessing memory. Sits between the core's mem* interface and the memory macro, which has 1-cycle read latency.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: the core always wins the port; secondary requests queue in a FIFO
// and issue only in core-idle cycles. Define MEM_ARB_STATS_EN to build deferral/issue counters.
module mem_port_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_read,
    input  logic [3:0]        core_wstrb,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    input  logic              sec_valid,
    output logic              sec_ready,
    input  logic [ADDR_W-1:0] sec_addr,
    input  logic [3:0]        sec_wstrb,
    input  logic [31:0]       sec_wdata,
    output logic              sec_rvalid,
    output logic [31:0]       sec_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       stat_defer_cnt,
    output logic [31:0]       stat_issue_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        wstrb;
        logic [31:0]       wdata;
    } req_t;

    req_t          r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ready;
    logic          r_rd_pend;
    logic [31:0]   r_rdata_hold;

    logic          w_core_busy, w_empty, w_push, w_pop;
    logic [CW-1:0] w_count_nxt;
    req_t          w_head;

    assign w_core_busy = core_read | (|core_wstrb);
    assign w_empty     = (r_count == '0);
    assign w_head      = r_fifo[r_rptr];
    assign w_push      = sec_valid & r_ready;
    assign w_pop       = ~w_core_busy & ~w_empty;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        mem_addr  = core_addr;
        mem_read  = core_read;
        mem_wstrb = core_wstrb;
        mem_wdata = core_wdata;
        if (w_pop) begin
            mem_addr  = w_head.addr;
            mem_read  = (w_head.wstrb == 4'b0000);
            mem_wstrb = w_head.wstrb;
            mem_wdata = w_head.wdata;
        end
    end

    // Payload storage carries no reset; validity lives entirely in count/pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= '{addr: sec_addr, wstrb: sec_wstrb, wdata: sec_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_ready      <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count   <= w_count_nxt;
            r_ready   <= (w_count_nxt != CW'(FIFO_DEPTH));
            r_rd_pend <= w_pop & (w_head.wstrb == 4'b0000);
            if (r_rd_pend) r_rdata_hold <= mem_rdata;
        end
    end

    assign sec_ready  = r_ready;
    assign sec_rvalid = r_rd_pend;
    // Read data is presented live in the response cycle, then held from the capture register.
    assign sec_rdata  = r_rd_pend ? mem_rdata : r_rdata_hold;
    assign core_rdata = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_defer_cnt, r_issue_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_defer_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (~w_empty & w_core_busy & (r_defer_cnt != 32'hFFFF_FFFF))
                r_defer_cnt <= r_defer_cnt + 32'd1;
            if (w_pop & (r_issue_cnt != 32'hFFFF_FFFF))
                r_issue_cnt <= r_issue_cnt + 32'd1;
        end
    end

    assign stat_defer_cnt = r_defer_cnt;
    assign stat_issue_cnt = r_issue_cnt;
`else
    assign stat_defer_cnt = '0;
    assign stat_issue_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed tests plus a queue-based reference model checked every cycle.
module tb_mem_port_arbiter;
    localparam int DEPTH = 4;

    logic        clk, rst;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_read;
    logic [3:0]  core_wstrb;
    logic        sec_valid, sec_ready, sec_rvalid;
    logic [31:0] sec_addr, sec_wdata, sec_rdata;
    logic [3:0]  sec_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic [31:0] stat_defer_cnt, stat_issue_cnt;

    mem_port_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .core_addr(core_addr), .core_read(core_read), .core_wstrb(core_wstrb),
        .core_wdata(core_wdata), .core_rdata(core_rdata),
        .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_addr(sec_addr),
        .sec_wstrb(sec_wstrb), .sec_wdata(sec_wdata),
        .sec_rvalid(sec_rvalid), .sec_rdata(sec_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_defer_cnt(stat_defer_cnt), .stat_issue_cnt(stat_issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] M40 = 32'h4040_1111;
    localparam logic [31:0] M80 = 32'h8080_2222;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Memory macro driven by the DUT: 1-cycle read latency, byte writes.
    logic [31:0] dmem [256];
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= dmem[mem_addr[9:2]];
        if (mem_wstrb != 4'b0000) dmem[mem_addr[9:2]] <= merge(dmem[mem_addr[9:2]], mem_wdata, mem_wstrb);
    end

    // Reference model: a queue of accepted requests and its own copy of memory.
    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } mreq_t;
    mreq_t       q[$];
    logic [31:0] rmem [256];
    logic        m_ready = 1'b0, m_pend = 1'b0;
    logic [31:0] m_hold = '0, m_mrd = '0;
    logic [31:0] m_defer = '0, m_issue = '0;

    initial begin
        forever begin
            logic        busy, pop, e_rd;
            logic [31:0] e_a, e_d;
            logic [3:0]  e_s;
            mreq_t       h;
            @(negedge clk);
            if (rst) begin
                q.delete();
                m_ready = 1'b0; m_pend = 1'b0; m_hold = '0; m_defer = '0; m_issue = '0;
            end
            busy = core_read || (core_wstrb != 4'b0000);
            pop  = !busy && (q.size() != 0);
            e_a = core_addr; e_rd = core_read; e_s = core_wstrb; e_d = core_wdata;
            if (pop) begin
                h = q[0];
                e_a = h.a; e_rd = (h.s == 4'b0000); e_s = h.s; e_d = h.d;
            end
            chk("mem_addr", mem_addr, e_a);
            chk("mem_read", 32'(mem_read), 32'(e_rd));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(e_s));
            chk("mem_wdata", mem_wdata, e_d);
            chk("sec_ready", 32'(sec_ready), 32'(m_ready));
            chk("sec_rvalid", 32'(sec_rvalid), 32'(m_pend));
            chk("sec_rdata", sec_rdata, m_pend ? m_mrd : m_hold);
            chk("core_rdata", core_rdata, m_mrd);
`ifdef MEM_ARB_STATS_EN
            chk("stat_defer", stat_defer_cnt, m_defer);
            chk("stat_issue", stat_issue_cnt, m_issue);
`else
            chk("stat_defer", stat_defer_cnt, 32'd0);
            chk("stat_issue", stat_issue_cnt, 32'd0);
`endif
            // Advance the model to the state after the coming rising edge.
            if (!rst) begin
                if (busy && q.size() != 0) m_defer++;
                if (pop) m_issue++;
                if (m_pend) m_hold = m_mrd;
                m_pend = pop && e_rd;
                if (pop) void'(q.pop_front());
                if (sec_valid && m_ready) q.push_back('{a: sec_addr, s: sec_wstrb, d: sec_wdata});
                m_ready = (q.size() != DEPTH);
            end
            if (e_rd) m_mrd = rmem[e_a[9:2]];
            if (e_s != 4'b0000) rmem[e_a[9:2]] = merge(rmem[e_a[9:2]], e_d, e_s);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sec_drive(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        sec_valid = 1'b1; sec_addr = a; sec_wstrb = s; sec_wdata = d;
    endtask

    task automatic sec_wait();
        logic ok;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            ok = sec_ready;
            step();
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
        sec_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        sec_drive(a, s, d);
        sec_wait();
    endtask

    task automatic do_reset();
        step();
        core_read = 1'b0; core_wstrb = '0; sec_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        logic acc, prev_busy;
        rst = 1'b1;
        core_addr = '0; core_read = 1'b0; core_wstrb = '0; core_wdata = '0;
        sec_valid = 1'b0; sec_addr = '0; sec_wstrb = '0; sec_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        dmem[16] = M40; dmem[32] = M80; dmem[64] = 32'hDEAD_BEEF; dmem[128] = 32'hFFFF_FFFF;
        for (int i = 0; i < 256; i++) rmem[i] = dmem[i];
        repeat (2) step();
        rst = 1'b0;
        step();

        // 1: idle core, single secondary read
        push(32'h100, 4'b0000, '0);
        @(negedge clk);
        chk("t1_mem_read", 32'(mem_read), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        @(negedge clk);
        chk("t1_rvalid", 32'(sec_rvalid), 32'd1);
        chk("t1_rdata", sec_rdata, 32'hDEAD_BEEF);

        // 2: core read collides with a queued secondary read
        do_reset();
        push(32'h80, 4'b0000, '0);
        core_read = 1'b1; core_addr = 32'h40;
        @(negedge clk);
        chk("t2_core_addr", mem_addr, 32'h40);
        step();
        core_read = 1'b0;
        @(negedge clk);
        chk("t2_sec_addr", mem_addr, 32'h80);
        chk("t2_core_rdata", core_rdata, M40);
`ifdef MEM_ARB_STATS_EN
        chk("t2_defer", stat_defer_cnt, 32'd1);
`endif
        step();
        @(negedge clk);
        chk("t2_sec_rdata", sec_rdata, M80);

        // 3: fill FIFO while core is busy, fifth request stalls
        do_reset();
        core_read = 1'b1; core_addr = 32'h40;
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i * 4), 4'b0000, '0);
        sec_drive(32'h314, 4'b0000, '0);
        @(negedge clk);
        chk("t3_full", 32'(sec_ready), 32'd0);
        step(); step();
        core_read = 1'b0;
        @(negedge clk);
        chk("t3_first", mem_addr, 32'h300);
        sec_wait();
        repeat (8) step();

        // 4: partial write then read-back
        do_reset();
        push(32'h200, 4'b0011, 32'h1234_ABCD);
        @(negedge clk);
        chk("t4_wstrb", 32'(mem_wstrb), 32'h3);
        step();
        @(negedge clk);
        chk("t4_no_rvalid", 32'(sec_rvalid), 32'd0);
        step();
        push(32'h200, 4'b0000, '0);
        @(negedge clk);
        chk("t4_rd", 32'(mem_read), 32'd1);
        @(negedge clk);
        chk("t4_rdata", sec_rdata, 32'hFFFF_ABCD);

        // 5: reset with queued entries and a read in flight
        do_reset();
        core_read = 1'b1; core_addr = 32'h40;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 4), 4'b0000, '0);
        core_read = 1'b0;
        step();
        core_read = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rvalid_rst", 32'(sec_rvalid), 32'd0);
        step();
        rst = 1'b0; core_read = 1'b0;
        step(); step();
        @(negedge clk);
        chk("t5_ready", 32'(sec_ready), 32'd1);
        chk("t5_no_read", 32'(mem_read), 32'd0);
        chk("t5_no_wstrb", 32'(mem_wstrb), 32'd0);
        repeat (4) step();

        // 6: random core activity (never back-to-back) with random secondary traffic
        do_reset();
        acc = 1'b0; prev_busy = 1'b0;
        for (int c = 0; c < 400; c++) begin
            int r;
            core_read = 1'b0; core_wstrb = '0;
            if (!prev_busy) begin
                r = $urandom_range(0, 5);
                core_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                core_wdata = $urandom;
                if (r < 2) core_read = 1'b1;
                else if (r == 2) core_wstrb = 4'($urandom_range(1, 15));
            end
            prev_busy = core_read || (core_wstrb != 4'b0000);
            if (!sec_valid || acc) begin
                if ($urandom_range(0, 1) == 1)
                    sec_drive({22'd0, 8'($urandom_range(0, 255)), 2'b00},
                              ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15)),
                              $urandom);
                else
                    sec_valid = 1'b0;
            end
            @(negedge clk);
            acc = sec_valid && sec_ready;
            step();
        end
        sec_valid = 1'b0; core_read = 1'b0; core_wstrb = '0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
